sobel_lb_ctrl: RTL
==================

Name: sobel_lb_ctrl

Overview:
- Frame sequencer for the Sobel line-buffer stage.
- Accepts a raster pixel stream and gates writes into fifo_double_line_buffer (DEPTH = IMG_W).
- Tracks column/row position, flags when the 3x3 window at the buffer outputs is complete, and reports the window-centre coordinates to the Sobel kernel.
- Clears the line buffer between frames and signals end of frame.

Parameters:
- IMG_W, 5, pixels per line; also the line buffer DEPTH; minimum 3.
- IMG_H, 4, lines per frame; minimum 3.
- CW, $clog2(IMG_W), column counter width.
- RW, $clog2(IMG_H), row counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start_i  in  1  begin a frame; honoured only in IDLE.
- abort_i  in  1  cancel the current frame.
- valid_i  in  1  pixel present on data_i.
- data_i  in  8  input pixel.
- ready_o  out  1  controller accepting pixels.
- lb_we_o  out  1  line-buffer write enable (= valid_i & ready_o, combinational).
- lb_data_o  out  8  line-buffer write data (= data_i).
- lb_clr_o  out  1  synchronous clear pulse to the line buffer.
- win_valid_o  out  1  3x3 window at the line-buffer outputs is complete.
- col_o  out  CW  window-centre column.
- row_o  out  RW  window-centre row.
- busy_o  out  1  frame in progress (not IDLE).
- frame_done_o  out  1  one-cycle end-of-frame pulse.
- err_o  out  1  sticky error: pixel offered while not ready.

Behaviour:
- Reset (rst=0, async): state=IDLE; counters=0. All outputs 0: ready_o, lb_clr_o, win_valid_o, col_o, row_o, busy_o, frame_done_o, err_o.
- Accept = valid_i & ready_o. Counters (col, row) advance only on accept.
  - col wraps IMG_W-1 -> 0 and increments row.
- States:
  - IDLE: ready_o=0. start_i -> CLEAR; also clears err_o.
  - CLEAR: lb_clr_o=1 for exactly one cycle; counters zeroed -> FILL.
  - FILL: ready_o=1, win_valid_o=0. Accepting pixel (1, IMG_W-1), i.e. last pixel of line 1 -> RUN.
  - RUN: ready_o=1. On accepting the last pixel (IMG_H-1, IMG_W-1) -> DONE.
  - DONE: ready_o=0; frame_done_o=1 for one cycle -> IDLE.
- win_valid_o: registered; high in the cycle after an accepted pixel at (r,c) with r>=2 and c>=2. That cycle is the cycle the line-buffer outputs present that window.
  - col_o=c-1, row_o=r-1, registered in the same cycle.
  - Otherwise win_valid_o=0; col_o/row_o hold their last values.
- Windows per frame: (IMG_H-2)*(IMG_W-2). No window is issued across a line wrap (c<2 suppressed).
- busy_o=1 in CLEAR, FILL, RUN, DONE.
- valid_i while ready_o=0 (IDLE, CLEAR, DONE): pixel dropped, err_o set.
  - err_o stays set until the next accepted start_i or reset.
- abort_i (any non-IDLE state): next state CLEAR, then FILL; the frame restarts at (0,0).
  - No frame_done_o pulse is generated for the aborted frame.
  - In IDLE, abort_i is ignored.
- start_i outside IDLE is ignored. start_i and abort_i together in IDLE: start wins.
- Gaps in valid_i during FILL/RUN: counters hold; win_valid_o=0 in the cycle following the gap.

Optional Feature:
- Macro SOBEL_LB_FRAME_CNT_EN.
- Defined: adds output frame_cnt_o [15:0].
  - Resets to 0; increments on each frame_done_o; wraps 0xFFFF -> 0.
  - Aborted frames are not counted.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then start_i pulse, stream 20 pixels 0..19 continuously (IMG_W=5, IMG_H=4).
  - -> lb_clr_o one cycle after start; ready_o=1 from FILL.
  - -> exactly 6 win_valid_o pulses, centres (1,1)(1,2)(1,3)(2,1)(2,2)(2,3).
  - -> frame_done_o one cycle after pixel 19 is accepted; busy_o falls to 0.
- Same stream with valid_i low every 3rd cycle.
  - -> same 6 windows and coordinates.
  - -> no win_valid_o in the cycle after a gap; counters frozen during gaps.
- valid_i=1 in IDLE with data 0xAA.
  - -> lb_we_o=0, err_o=1 and held.
  - -> next start_i clears err_o.
- abort_i asserted after pixel 8 of frame.
  - -> lb_clr_o pulse, counters back to 0, no frame_done_o.
  - -> a subsequent full 20-pixel frame yields exactly 6 windows.
- rst low for one cycle mid-RUN.
  - -> all outputs 0 immediately (async); state IDLE; ready_o=0 until a new start_i.
- With SOBEL_LB_FRAME_CNT_EN: three complete frames plus one aborted frame.
  - -> frame_cnt_o=3.

Source files
------------

// File: rtl/sobel_lb_ctrl.sv
// sobel_lb_ctrl: frame sequencer for the Sobel line-buffer stage.
// It gates raster pixels into a double line buffer of depth IMG_W. It tracks
// the column/row of each accepted pixel and flags when a full 3x3 window sits
// at the buffer outputs, along with that window's centre coordinates.
// Optional build macro SOBEL_LB_FRAME_CNT_EN adds a 16-bit completed-frame counter.
//
// Handshake: a pixel is accepted in a cycle where valid_i & ready_o are both high.
// ready_o is a function of state only. A pixel offered while ready_o is low is
// dropped and sets the sticky err_o flag.
module sobel_lb_ctrl #(
  parameter int IMG_W = 5,
  parameter int IMG_H = 4,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          valid_i,
  input  logic [7:0]    data_i,
  output logic          ready_o,
  output logic          lb_we_o,
  output logic [7:0]    lb_data_o,
  output logic          lb_clr_o,
  output logic          win_valid_o,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          busy_o,
  output logic          frame_done_o,
  output logic          err_o,
`ifdef SOBEL_LB_FRAME_CNT_EN
  output logic [15:0]   frame_cnt_o,
`endif
  output logic [2:0]    dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FILL  = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t        state, state_nx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          accept;
  logic          at_col_last;

  assign ready_o      = (state == FILL) || (state == RUN);
  assign accept       = valid_i & ready_o;
  assign lb_we_o      = accept;
  assign lb_data_o    = data_i;
  assign lb_clr_o     = (state == CLEAR);
  assign busy_o       = (state != IDLE);
  assign frame_done_o = (state == DONE);
  assign dbg_state_o  = state;
  assign at_col_last  = (col == COL_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic; abort restarts any active frame through CLEAR.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start_i) state_nx = CLEAR;
      CLEAR: if (!abort_i) state_nx = FILL;
      FILL: begin
        if (abort_i) state_nx = CLEAR;
        else if (accept && at_col_last && row == RW'(1)) state_nx = RUN;
      end
      RUN: begin
        if (abort_i) state_nx = CLEAR;
        else if (accept && at_col_last && row == ROW_LAST) state_nx = DONE;
      end
      DONE:  state_nx = abort_i ? CLEAR : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Raster position of the next pixel; zeroed while the buffer is cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (state == CLEAR) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (at_col_last) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Window flag and centre; the pixel at (r,c) completes the window centred at (r-1,c-1).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_valid_o <= 1'b0;
      col_o       <= '0;
      row_o       <= '0;
    end else begin
      win_valid_o <= 1'b0;
      if (accept && row >= RW'(2) && col >= CW'(2)) begin
        win_valid_o <= 1'b1;
        col_o       <= col - CW'(1);
        row_o       <= row - RW'(1);
      end
    end
  end

  // Sticky drop error; a new start clears it unless a pixel is dropped that same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        err_o <= 1'b0;
    else if (valid_i && !ready_o)    err_o <= 1'b1;
    else if (state == IDLE && start_i) err_o <= 1'b0;
  end

`ifdef SOBEL_LB_FRAME_CNT_EN
  // Completed-frame counter; aborted frames never reach DONE so they are not counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               frame_cnt_o <= '0;
    else if (state == DONE) frame_cnt_o <= frame_cnt_o + 16'd1;
  end
`endif

endmodule
